// File: rtl/mem_access_unit.sv
// Memory-stage access controller: request/ack handshake with data memory, store lane steering, load extraction.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and raise out_misaligned.
module mem_access_unit #(
    parameter int BUS_WIDTH   = 64,
    parameter int REGFILE_LEN = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_reg_write,
    input  logic                   in_mem_write,
    input  logic                   in_mem_read,
    input  logic                   in_mem_to_reg,
    input  logic [REGFILE_LEN-1:0] in_rd,
    input  logic [2:0]             in_funct3,
    input  logic [BUS_WIDTH-1:0]   in_alu_fpu_result,
    input  logic [BUS_WIDTH-1:0]   in_store_data,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [BUS_WIDTH-1:0]   dmem_addr,
    output logic [BUS_WIDTH-1:0]   dmem_wdata,
    output logic [7:0]             dmem_wstrb,
    input  logic                   dmem_ack,
    input  logic [BUS_WIDTH-1:0]   dmem_rdata,
    output logic                   stall,
    output logic                   out_reg_write,
    output logic                   out_mem_to_reg,
    output logic [REGFILE_LEN-1:0] out_rd,
    output logic [BUS_WIDTH-1:0]   out_alu_fpu_result,
    output logic [BUS_WIDTH-1:0]   out_load_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                   out_misaligned
`endif
);

    // state | meaning
    // IDLE  | pass-through; latch request when an access is pending
    // WAIT  | dmem_req held until dmem_ack
    // DONE  | result valid, no stall; EX/MEM advances on this edge
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           pending, trap;
    logic [2:0]     size_mask, lane_off, off_q, funct3_q;
    logic [7:0]     strb;
    logic [BUS_WIDTH-1:0] rd_shift, load_ext;
    logic           misaligned_q;

    assign pending = in_mem_read | in_mem_write;

    always_comb begin
        size_mask = 3'b111;
        strb      = 8'hFF;
        case (in_funct3[1:0])
            2'd0: begin size_mask = 3'b000; strb = 8'h01 << lane_off; end
            2'd1: begin size_mask = 3'b001; strb = 8'h03 << lane_off; end
            2'd2: begin size_mask = 3'b011; strb = 8'h0F << lane_off; end
            default: begin size_mask = 3'b111; strb = 8'hFF; end
        endcase
    end

    // Dropping the sub-size offset bits makes a misaligned access land on its natural lane.
    assign lane_off = in_alu_fpu_result[2:0] & ~size_mask;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = |(in_alu_fpu_result[2:0] & size_mask);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pending) state_d = trap ? S_DONE : S_WAIT;
            S_WAIT:  if (dmem_ack) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_shift = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = rd_shift;
        case (funct3_q)
            3'b000:  load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b100:  load_ext = {56'd0, rd_shift[7:0]};
            3'b101:  load_ext = {48'd0, rd_shift[15:0]};
            3'b110:  load_ext = {32'd0, rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_wstrb    <= 8'h00;
            funct3_q      <= 3'b000;
            off_q         <= 3'b000;
            out_load_data <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= (state_q == S_IDLE) && pending && trap;
            if (state_q == S_IDLE && pending && !trap) begin
                dmem_req   <= 1'b1;
                dmem_we    <= in_mem_write;
                dmem_addr  <= {in_alu_fpu_result[BUS_WIDTH-1:3], 3'b000};
                dmem_wdata <= in_store_data << {lane_off, 3'b000};
                dmem_wstrb <= strb;
                funct3_q   <= in_funct3;
                off_q      <= lane_off;
            end
            if (state_q == S_WAIT && dmem_ack) begin
                dmem_req <= 1'b0;
                if (!dmem_we) out_load_data <= load_ext;
            end
        end
    end

    assign stall              = (state_q == S_IDLE && pending) || (state_q == S_WAIT);
    assign out_rd             = in_rd;
    assign out_mem_to_reg     = in_mem_to_reg;
    assign out_alu_fpu_result = in_alu_fpu_result;

`ifdef MEM_MISALIGN_TRAP_EN
    assign out_misaligned = misaligned_q;
    assign out_reg_write  = in_reg_write & ~stall & ~misaligned_q;
`else
    assign out_reg_write  = in_reg_write & ~stall;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, loads/stores per size, memory wait, reset mid-access.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_reg_write, in_mem_write, in_mem_read, in_mem_to_reg;
    logic [5:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [63:0] in_alu_fpu_result, in_store_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic        stall, out_reg_write, out_mem_to_reg;
    logic [5:0]  out_rd;
    logic [63:0] out_alu_fpu_result, out_load_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        out_misaligned;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.BUS_WIDTH(64), .REGFILE_LEN(6)) dut (
        .clk(clk), .rst(rst),
        .in_reg_write(in_reg_write), .in_mem_write(in_mem_write),
        .in_mem_read(in_mem_read), .in_mem_to_reg(in_mem_to_reg),
        .in_rd(in_rd), .in_funct3(in_funct3),
        .in_alu_fpu_result(in_alu_fpu_result), .in_store_data(in_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_rd(out_rd), .out_alu_fpu_result(out_alu_fpu_result),
        .out_load_data(out_load_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .out_misaligned(out_misaligned)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        in_reg_write = 0; in_mem_write = 0; in_mem_read = 0; in_mem_to_reg = 0;
        in_rd = 0; in_funct3 = 0; in_alu_fpu_result = 0; in_store_data = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one memory instruction and serves it; returns in its DONE cycle.
    task automatic mem_op(input string tag, input logic is_wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sdata, input int wait_n,
                          input logic [63:0] rdata, input int exp_stall, input int exp_req);
        int n_stall = 0;
        int n_req = 0;
        logic done = 0;
        logic moved = 0;
        logic [63:0] a0 = 0;
        in_mem_read = ~is_wr; in_mem_write = is_wr;
        in_reg_write = ~is_wr; in_mem_to_reg = ~is_wr;
        in_rd = 6'd7; in_funct3 = f3; in_alu_fpu_result = addr; in_store_data = sdata;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (stall) n_stall++;
            if (dmem_req) begin
                n_req++;
                if (n_req == 1) a0 = dmem_addr;
                else if (dmem_addr !== a0) moved = 1;
                if (n_req == wait_n + 1) begin
                    dmem_ack = 1; dmem_rdata = rdata;
                end
            end
            if (!stall) done = 1;
            else begin
                @(posedge clk);
                #1;
                dmem_ack = 0; dmem_rdata = 0;
            end
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_stall_cycles"}, 64'(n_stall), 64'(exp_stall));
        chk({tag, "_req_cycles"}, 64'(n_req), 64'(exp_req));
        chk({tag, "_addr_stable"}, 64'(moved), 64'd0);
        chk({tag, "_req_low_done"}, 64'(dmem_req), 64'd0);
    endtask

    initial begin
        clear_in();
        rst = 0;
        #2;
        chk("rst_req",   64'(dmem_req), 64'd0);
        chk("rst_we",    64'(dmem_we), 64'd0);
        chk("rst_addr",  dmem_addr, 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_wstrb", 64'(dmem_wstrb), 64'd0);
        chk("rst_load",  out_load_data, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1;
        next_cycle();

        // ALU op: pure pass-through
        in_reg_write = 1; in_alu_fpu_result = 64'h1234; in_rd = 6'd3; in_mem_to_reg = 0;
        #1;
        chk("add_stall", 64'(stall), 64'd0);
        chk("add_req",   64'(dmem_req), 64'd0);
        chk("add_rw",    64'(out_reg_write), 64'd1);
        chk("add_res",   out_alu_fpu_result, 64'h1234);
        chk("add_rd",    64'(out_rd), 64'd3);
        next_cycle();
        chk("add_req_next", 64'(dmem_req), 64'd0);

        // LB from 0x1003, byte3 = 0x85
        mem_op("lb", 0, 3'b000, 64'h1003, 0, 0, 64'h80FF_0000_8500_0000, 2, 1);
        chk("lb_addr", dmem_addr, 64'h1000);
        chk("lb_data", out_load_data, 64'hFFFF_FFFF_FFFF_FF85);
        chk("lb_rw",   64'(out_reg_write), 64'd1);
        chk("lb_rd",   64'(out_rd), 64'd7);
        next_cycle();
        mem_op("lbu", 0, 3'b100, 64'h1003, 0, 0, 64'h80FF_0000_8500_0000, 2, 1);
        chk("lbu_data", out_load_data, 64'h85);
        next_cycle();

        // SH 0xBEEF at 0x2006
        mem_op("sh", 1, 3'b001, 64'h2006, 64'hBEEF, 0, 0, 2, 1);
        chk("sh_we",    64'(dmem_we), 64'd1);
        chk("sh_wstrb", 64'(dmem_wstrb), 64'hC0);
        chk("sh_wdata", dmem_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_rw",    64'(out_reg_write), 64'd0);
        chk("sh_load_kept", out_load_data, 64'h85);
        next_cycle();

        // LD at 0x3000, ack after 5 wait cycles (back-to-back with SH)
        mem_op("ld", 0, 3'b011, 64'h3000, 0, 5, 64'h0123_4567_89AB_CDEF, 7, 6);
        chk("ld_addr",  dmem_addr, 64'h3000);
        chk("ld_wstrb", 64'(dmem_wstrb), 64'hFF);
        chk("ld_data",  out_load_data, 64'h0123_4567_89AB_CDEF);
        next_cycle();

        // Upper-half and word loads
        mem_op("lh", 0, 3'b001, 64'h5006, 0, 1, 64'hF00D_0000_0000_0000, 3, 2);
        chk("lh_data", out_load_data, 64'hFFFF_FFFF_FFFF_F00D);
        next_cycle();
        mem_op("lhu", 0, 3'b101, 64'h5006, 0, 0, 64'hF00D_0000_0000_0000, 2, 1);
        chk("lhu_data", out_load_data, 64'hF00D);
        next_cycle();
        mem_op("lwu", 0, 3'b110, 64'h6004, 0, 0, 64'h8765_4321_0000_0000, 2, 1);
        chk("lwu_data", out_load_data, 64'h8765_4321);
        next_cycle();

        // Store lanes
        mem_op("sw", 1, 3'b010, 64'h7004, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 2, 1);
        chk("sw_wstrb", 64'(dmem_wstrb), 64'hF0);
        chk("sw_wdata", dmem_wdata, 64'hDEAD_BEEF_0000_0000);
        next_cycle();
        mem_op("sb", 1, 3'b000, 64'h8001, 64'h1234_56AB, 0, 0, 2, 1);
        chk("sb_wstrb", 64'(dmem_wstrb), 64'h02);
        chk("sb_wdata", dmem_wdata, 64'h12_3456_AB00);
        chk("sb_addr",  dmem_addr, 64'h8000);
        next_cycle();
        mem_op("sd", 1, 3'b011, 64'h9000, 64'hCAFE_F00D_1234_5678, 0, 0, 2, 1);
        chk("sd_wstrb", 64'(dmem_wstrb), 64'hFF);
        chk("sd_wdata", dmem_wdata, 64'hCAFE_F00D_1234_5678);
        next_cycle();

        // Misaligned LW at 0x4002
`ifdef MEM_MISALIGN_TRAP_EN
        mem_op("lw_mis", 0, 3'b010, 64'h4002, 0, 0, 64'h1122_3344_8000_0001, 1, 0);
        chk("lw_mis_flag", 64'(out_misaligned), 64'd1);
        chk("lw_mis_rw",   64'(out_reg_write), 64'd0);
        chk("lw_mis_load", out_load_data, 64'h8765_4321);
        next_cycle();
        clear_in();
        #1;
        chk("lw_mis_flag_clr", 64'(out_misaligned), 64'd0);
`else
        mem_op("lw_mask", 0, 3'b010, 64'h4002, 0, 0, 64'h1122_3344_8000_0001, 2, 1);
        chk("lw_mask_addr",  dmem_addr, 64'h4000);
        chk("lw_mask_wstrb", 64'(dmem_wstrb), 64'h0F);
        chk("lw_mask_data",  out_load_data, 64'hFFFF_FFFF_8000_0001);
        next_cycle();
        clear_in();
`endif
        next_cycle();

        // Reset while waiting for ack
        in_mem_read = 1; in_reg_write = 1; in_funct3 = 3'b011; in_alu_fpu_result = 64'hA000;
        next_cycle();
        chk("rwait_req", 64'(dmem_req), 64'd1);
        rst = 0;
        #1;
        chk("rwait_req_drop", 64'(dmem_req), 64'd0);
        chk("rwait_load", out_load_data, 64'd0);
        clear_in();
        @(negedge clk);
        rst = 1;
        dmem_ack = 1; dmem_rdata = 64'h5555_5555_5555_5555;
        next_cycle();
        dmem_ack = 0; dmem_rdata = 0;
        #1;
        chk("rwait_late_ack_load", out_load_data, 64'd0);
        chk("rwait_late_ack_req",  64'(dmem_req), 64'd0);
        chk("rwait_idle_stall",    64'(stall), 64'd0);
        next_cycle();
        mem_op("lb_after_rst", 0, 3'b000, 64'hB007, 0, 0, 64'h7F00_0000_0000_0000, 2, 1);
        chk("lb_after_rst_data", out_load_data, 64'h7F);
        next_cycle();
        clear_in();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller of the 64-bit pipeline. Consumes the control, address and store data held in the EX/MEM pipeline register, runs a request/acknowledge transaction with data memory, and formats load data. Drives `stall` back to the upstream pipeline registers until the access completes. Presents writeback-ready results to the MEM/WB register.

## Interface
- `BUS_WIDTH`, 64, datapath and address width; must be 64, because lane logic assumes 8 byte lanes.
- `REGFILE_LEN`, 6, width of register index fields.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_reg_write`, `in_mem_write`, `in_mem_read`, `in_mem_to_reg`  in  1 each  control bits from EX/MEM.
- `in_rd`  in  REGFILE_LEN  destination register.
- `in_funct3`  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
- `in_alu_fpu_result`  in  BUS_WIDTH  effective address for memory ops; result for all others.
- `in_store_data`  in  BUS_WIDTH  rs2 value, right-aligned.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  BUS_WIDTH  address with bits [2:0] forced to 0.
- `dmem_wdata`  out  BUS_WIDTH  store data shifted to its lanes.
- `dmem_wstrb`  out  8  byte enables.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `dmem_rdata`  in  BUS_WIDTH  read doubleword; valid only in the `dmem_ack` cycle.
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- `out_reg_write`, `out_mem_to_reg`  out  1 each  to MEM/WB.
- `out_rd`  out  REGFILE_LEN  to MEM/WB.
- `out_alu_fpu_result`  out  BUS_WIDTH  pass-through.
- `out_load_data`  out  BUS_WIDTH  extended load value.
- `out_misaligned`  out  1  misaligned-access flag; present only with the macro defined.

## Operation
- The block has three states: IDLE, WAIT and DONE.
- An access is pending when `in_mem_read | in_mem_write` is high.
- **IDLE**
  - With no access pending, the block is a pure pass-through and `stall` = 0.
  - When an access is pending, it latches address, `we`, shifted `wdata`, `wstrb`, `funct3` and `addr[2:0]`, then goes to WAIT.
- **WAIT**
  - `dmem_req` = 1 and the latched request fields are held stable until `dmem_ack`.
  - On `dmem_ack` for a read, the block byte-selects `dmem_rdata` using the latched `addr[2:0]`, sign- or zero-extends it per `funct3`, and registers the result into the load register. The transition is WAIT -> DONE.
  - On `dmem_ack` for a write, the transition is WAIT -> DONE and the load register is unchanged.
- **DONE**
  - `stall` = 0 and the outputs are valid.
  - Unconditional transition DONE -> IDLE, by which point EX/MEM has advanced to the next instruction.
- `stall` = (IDLE & pending) | WAIT. It is combinational.
- `out_reg_write` = `in_reg_write` & ~`stall`, so the MEM/WB register sees a bubble while stalled.
- `out_rd`, `out_mem_to_reg` and `out_alu_fpu_result` are combinational pass-throughs.
- Strobes:
  - byte: `1 << a[2:0]`
  - half: `0x3 << a[2:0]`
  - word: `0xF << a[2:0]`
  - double: `0xFF`
- `wdata` = `in_store_data << (8*a[2:0])`, truncated to 64 bits.
- `dmem_ack` is ignored in IDLE and DONE.

## Timing
- Memory access latency is 2 cycles plus the memory wait (W = cycles from first `dmem_req` to `dmem_ack`, W ≥ 0):
  - `stall` is high for 2+W cycles.
  - The instruction completes in the DONE cycle.
- `dmem_req` is registered: it rises the cycle after detection and falls the cycle after `ack`.
- Non-memory instructions have 0 added latency.
- Reset values, applied asynchronously on `rst` low:
  - state = IDLE
  - `dmem_req`, `dmem_we` = 0
  - `dmem_addr`, `dmem_wdata` = 0
  - `dmem_wstrb` = 0
  - `out_load_data` = 0
  - `out_misaligned` = 0
- Reset mid-transaction: `dmem_req` drops immediately, any in-flight `ack` is discarded, and no writeback occurs.
- Back-to-back accesses: DONE -> IDLE, then the next access is detected in that IDLE cycle. There is no dead cycle beyond that.

## Configuration
- `MEM_MISALIGN_TRAP_EN`, defined:
  - An access is misaligned when its `addr[2:0]` is not a multiple of the access size.
  - In IDLE, a misaligned access goes directly to DONE with no `dmem_req`.
  - `out_misaligned` is 1 during that DONE cycle and `out_reg_write` is forced to 0.
- `MEM_MISALIGN_TRAP_EN`, undefined:
  - The `out_misaligned` port is absent.
  - Misaligned `addr` low bits are masked down to the access size before lane selection.

## Test plan
- ADD with reg_write=1, result 0x1234, no memory op -> `stall` = 0, `dmem_req` never asserted, `out_reg_write` = 1, `out_alu_fpu_result` = 0x1234 in the same cycle.
- LB from addr 0x1003, `dmem_rdata` = 0x80FF_0000_0000_0000 except byte3 = 0x85, ack at W=0 -> `dmem_addr` = 0x1000, `stall` high for 2 cycles, `out_load_data` = 0xFFFF_FFFF_FFFF_FF85. The same access with LBU -> `out_load_data` = 0x85.
- SH of 0xBEEF at addr 0x2006 -> `dmem_we` = 1, `dmem_wstrb` = 0xC0, `dmem_wdata[63:48]` = 0xBEEF, `out_reg_write` = 0.
- LD at addr 0x3000 with `dmem_ack` delayed 5 cycles -> `dmem_req` and address stable for 6 cycles, `stall` high for 7 cycles, load value equals `dmem_rdata`.
- `rst` low during WAIT -> `dmem_req` = 0 before the next edge, state = IDLE, a later `ack` has no effect.
- Macro defined, LW at 0x4002 -> no `dmem_req`, `out_misaligned` = 1 for one cycle, `out_reg_write` = 0. Macro undefined -> request to 0x4000 with `wstrb` 0x0F.
